// File: rtl/cmac_axis_pkt_mon.sv
// Purpose: checks CMAC RX AXIS frames against a fixed length and incrementing-byte payload, and counts good/bad frames.
// Latency: state and counters update one aclk after the beat that causes them (async reset acts immediately).
// Backpressure: none; there is no tready, so every valid beat is consumed in the cycle it arrives.
module cmac_axis_pkt_mon #(
    parameter int PKT_NUM  = 1000,
    parameter int PKT_SIZE = 522
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         stat_rx_aligned,
    input  logic         rx_restart,
    input  logic         rx_continuous,
    input  logic         rx_axis_tvalid,
    input  logic [511:0] rx_axis_tdata,
    input  logic [63:0]  rx_axis_tkeep,
    input  logic         rx_axis_tlast,
    input  logic         rx_axis_tuser,
    output logic [31:0]  rx_pkt_cnt,
    output logic [47:0]  rx_byte_cnt,
    output logic [15:0]  rx_fcs_err_cnt,
    output logic [15:0]  rx_len_err_cnt,
    output logic [15:0]  rx_data_err_cnt,
    output logic [1:0]   rx_state,
    output logic         rx_busy_led,
    output logic         rx_done_led
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RX   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Longest legal frame in beats; the beat index parks here so the length cannot wrap.
    localparam logic [7:0]  MAX_BEATS = 8'((PKT_SIZE + 63) / 64);
    localparam logic [13:0] PKT_LEN   = 14'(PKT_SIZE);
    localparam logic [32:0] PKT_TOTAL = 33'(PKT_NUM);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  beat_idx;
    logic [1:0]  phase;
    logic        len_flag;
    logic        data_flag;

    logic        beat_ev;
    logic        last_ev;
    logic        over;
    logic        keep_bad;
    logic        mismatch;
    logic [6:0]  popcnt;
    logic [13:0] frame_len;
    logic        frame_len_err;
    logic        frame_data_err;
    logic        hit_total;
    logic [48:0] byte_sum;

    // Evaluate the beat on the bus: keep shape, payload pattern and the running frame length.
    always_comb begin
        beat_ev  = (state == RX) && rx_axis_tvalid && stat_rx_aligned && !rx_restart;
        last_ev  = beat_ev && rx_axis_tlast;
        over     = (beat_idx == MAX_BEATS);
        if (rx_axis_tlast) begin
            // A legal last-beat keep is 2^n-1: non-zero and no holes above the lowest zero.
            keep_bad = (rx_axis_tkeep == '0) ||
                       ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) != '0);
        end else begin
            keep_bad = (rx_axis_tkeep != '1);
        end
        popcnt   = '0;
        mismatch = 1'b0;
        for (int lane = 0; lane < 64; lane++) begin
            popcnt = popcnt + 7'(rx_axis_tkeep[lane]);
            // Byte index low bits are (beat_idx*64 + lane)[7:0] = {beat_idx[1:0], lane}.
            if (rx_axis_tkeep[lane] && (rx_axis_tdata[8*lane +: 8] != {phase, 6'(lane)})) begin
                mismatch = 1'b1;
            end
        end
        frame_len      = {beat_idx, 6'd0} + 14'(popcnt);
        frame_len_err  = len_flag || over || keep_bad || (frame_len != PKT_LEN);
        frame_data_err = data_flag || mismatch;
        hit_total      = (({1'b0, rx_pkt_cnt} + 33'd1) == PKT_TOTAL);
        byte_sum       = {1'b0, rx_byte_cnt} + 49'(frame_len);
    end

    // Next-state logic: restart and alignment loss override everything else.
    always_comb begin
        state_nxt = state;
        if (rx_restart || !stat_rx_aligned) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    if (rx_axis_tvalid && rx_axis_tlast) state_nxt = RX;
                RX:      if (last_ev && hit_total && !rx_continuous) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-frame tracking; cleared at frame end, restart or alignment loss.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_idx  <= '0;
            phase     <= '0;
            len_flag  <= 1'b0;
            data_flag <= 1'b0;
        end else if (rx_restart || !stat_rx_aligned || last_ev) begin
            beat_idx  <= '0;
            phase     <= '0;
            len_flag  <= 1'b0;
            data_flag <= 1'b0;
        end else if (beat_ev) begin
            if (!over) beat_idx <= beat_idx + 8'd1;
            phase     <= phase + 2'd1;
            len_flag  <= len_flag || over || keep_bad;
            data_flag <= data_flag || mismatch;
        end
    end

    // Saturating statistics, committed on the last beat of each frame seen in RX.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_pkt_cnt      <= '0;
            rx_byte_cnt     <= '0;
            rx_fcs_err_cnt  <= '0;
            rx_len_err_cnt  <= '0;
            rx_data_err_cnt <= '0;
        end else if (rx_restart) begin
            rx_pkt_cnt      <= '0;
            rx_byte_cnt     <= '0;
            rx_fcs_err_cnt  <= '0;
            rx_len_err_cnt  <= '0;
            rx_data_err_cnt <= '0;
        end else if (last_ev) begin
            if (rx_pkt_cnt != '1) rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
            rx_byte_cnt <= byte_sum[48] ? '1 : byte_sum[47:0];
            if (rx_axis_tuser && (rx_fcs_err_cnt != '1)) rx_fcs_err_cnt <= rx_fcs_err_cnt + 16'd1;
            if (frame_len_err && (rx_len_err_cnt != '1)) rx_len_err_cnt <= rx_len_err_cnt + 16'd1;
            if (frame_data_err && (rx_data_err_cnt != '1)) rx_data_err_cnt <= rx_data_err_cnt + 16'd1;
        end
    end

    assign rx_state    = state;
    assign rx_busy_led = (state == SYNC) || (state == RX);
    assign rx_done_led = (state == DONE);

endmodule

// File: tb/tb_cmac_axis_pkt_mon.sv
// Purpose: randomized scoreboard bench for cmac_axis_pkt_mon against a frame-level reference model.
// Latency: expects every output change one aclk after the causing beat; reset acts between edges.
// Backpressure: none; the bench drives beats freely with random idle gaps.
module tb_cmac_axis_pkt_mon;
    localparam int PKT_NUM  = 1000;
    localparam int PKT_SIZE = 522;
    localparam int MAXB     = (PKT_SIZE + 63) / 64;

    logic         aclk            = 1'b0;
    logic         aresetn         = 1'b1;
    logic         stat_rx_aligned = 1'b0;
    logic         rx_restart      = 1'b0;
    logic         rx_continuous   = 1'b0;
    logic         rx_axis_tvalid  = 1'b0;
    logic [511:0] rx_axis_tdata   = '0;
    logic [63:0]  rx_axis_tkeep   = '0;
    logic         rx_axis_tlast   = 1'b0;
    logic         rx_axis_tuser   = 1'b0;
    logic [31:0]  rx_pkt_cnt;
    logic [47:0]  rx_byte_cnt;
    logic [15:0]  rx_fcs_err_cnt;
    logic [15:0]  rx_len_err_cnt;
    logic [15:0]  rx_data_err_cnt;
    logic [1:0]   rx_state;
    logic         rx_busy_led;
    logic         rx_done_led;

    cmac_axis_pkt_mon #(.PKT_NUM(PKT_NUM), .PKT_SIZE(PKT_SIZE)) dut (
        .aclk(aclk), .aresetn(aresetn), .stat_rx_aligned(stat_rx_aligned),
        .rx_restart(rx_restart), .rx_continuous(rx_continuous),
        .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata),
        .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
        .rx_axis_tuser(rx_axis_tuser), .rx_pkt_cnt(rx_pkt_cnt),
        .rx_byte_cnt(rx_byte_cnt), .rx_fcs_err_cnt(rx_fcs_err_cnt),
        .rx_len_err_cnt(rx_len_err_cnt), .rx_data_err_cnt(rx_data_err_cnt),
        .rx_state(rx_state), .rx_busy_led(rx_busy_led), .rx_done_led(rx_done_led)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] pkt;
        logic [47:0] bytes;
        logic [15:0] fcs;
        logic [15:0] lerr;
        logic [15:0] derr;
        logic        busy;
        logic        done;
    } snap_t;

    snap_t expq[$];
    snap_t last_push;
    int    n_chk  = 0;
    int    n_pass = 0;
    int    gap_pct = 0;

    // Reference model: spec state plus frame collected as a list of keeps.
    int          m_st   = 0;
    longint      m_pkt  = 0;
    longint      m_bytes = 0;
    int          m_fcs  = 0;
    int          m_len  = 0;
    int          m_data = 0;
    logic [63:0] f_keep[$];
    bit          f_dbad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.st    = 2'(m_st);
        s.pkt   = 32'(m_pkt);
        s.bytes = 48'(m_bytes);
        s.fcs   = 16'(m_fcs);
        s.lerr  = 16'(m_len);
        s.derr  = 16'(m_data);
        s.busy  = (m_st == 1) || (m_st == 2);
        s.done  = (m_st == 3);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.st = rx_state; s.pkt = rx_pkt_cnt; s.bytes = rx_byte_cnt;
        s.fcs = rx_fcs_err_cnt; s.lerr = rx_len_err_cnt; s.derr = rx_data_err_cnt;
        s.busy = rx_busy_led; s.done = rx_done_led;
        return s;
    endfunction

    task automatic push_exp();
        snap_t s;
        s = model_snap();
        if (s != last_push) begin
            expq.push_back(s);
            last_push = s;
        end
    endtask

    task automatic model_zero();
        m_pkt = 0; m_bytes = 0; m_fcs = 0; m_len = 0; m_data = 0;
    endtask

    task automatic model_beat(input logic [63:0] k, input logic [511:0] d);
        int b;
        f_keep.push_back(k);
        b = f_keep.size() - 1;
        for (int l = 0; l < 64; l++)
            if (k[l] && (d[8*l +: 8] != 8'(64*b + l))) f_dbad = 1;
    endtask

    // Frame verdict from the whole frame: keep shapes, beat count and total length.
    task automatic model_frame_end(input logic user);
        int nb, pc, len;
        bit lerr;
        logic [63:0] lk, mask;
        nb = f_keep.size();
        lk = f_keep[nb-1];
        pc = $countones(lk);
        lerr = 0;
        for (int b = 0; b < nb - 1; b++)
            if (f_keep[b] != {64{1'b1}}) lerr = 1;
        mask = (64'd1 << pc) - 64'd1;
        if (pc == 0 || lk != mask) lerr = 1;
        if (nb > MAXB) lerr = 1;
        len = 64 * ((nb - 1 < MAXB) ? nb - 1 : MAXB) + pc;
        if (len != PKT_SIZE) lerr = 1;
        if (m_pkt < 64'hFFFF_FFFF) m_pkt++;
        m_bytes = (m_bytes + len > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : m_bytes + len;
        if (user && m_fcs < 16'hFFFF) m_fcs++;
        if (lerr && m_len < 16'hFFFF) m_len++;
        if (f_dbad && m_data < 16'hFFFF) m_data++;
        f_keep.delete();
        f_dbad = 0;
    endtask

    // Drive one clock of inputs, advance the model, and wait until just after the edge.
    task automatic cycle(input logic v, input logic [511:0] d, input logic [63:0] k,
                         input logic l, input logic u, input logic al, input logic rs);
        rx_axis_tvalid = v; rx_axis_tdata = d; rx_axis_tkeep = k;
        rx_axis_tlast = l; rx_axis_tuser = u; stat_rx_aligned = al; rx_restart = rs;
        if (rs) begin
            model_zero(); m_st = 0; f_keep.delete(); f_dbad = 0;
        end else if (!al && m_st != 0) begin
            m_st = 0; f_keep.delete(); f_dbad = 0;
        end else begin
            case (m_st)
                0: if (al) m_st = 1;
                1: if (v && l) m_st = 2;
                2: if (v) begin
                    model_beat(k, d);
                    if (l) begin
                        model_frame_end(u);
                        if (!rx_continuous && m_pkt == PKT_NUM) m_st = 3;
                    end
                end
                default: ;
            endcase
        end
        push_exp();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] pat_beat(input int b);
        logic [511:0] d;
        for (int l = 0; l < 64; l++) d[8*l +: 8] = 8'(64*b + l);
        return d;
    endfunction

    task automatic idle(input logic al, input logic rs);
        cycle(1'b0, rand512(), 64'($urandom), 1'($urandom), 1'($urandom), al, rs);
    endtask

    // Beats b0..nb-1 of a frame; optional corrupt byte, holed middle keep, restart on last beat.
    task automatic send_frame(input int b0, input int nb, input logic [63:0] last_keep,
                              input int bad_idx, input logic user, input int bad_keep_beat,
                              input logic rs_last);
        for (int b = b0; b < nb; b++) begin
            logic [511:0] d;
            logic [63:0]  k;
            logic         last;
            while (int'($urandom_range(99)) < gap_pct) idle(1'b1, 1'b0);
            last = (b == nb - 1);
            d = pat_beat(b);
            if (bad_idx >= 64*b && bad_idx < 64*b + 64) d[8*(bad_idx - 64*b) +: 8] = 8'h00;
            k = last ? last_keep : {64{1'b1}};
            if (b == bad_keep_beat && !last) k[5] = 1'b0;
            cycle(1'b1, d, k, last, last ? user : 1'($urandom), 1'b1, last ? rs_last : 1'b0);
        end
    endtask

    task automatic send_good();
        send_frame(0, 9, 64'h3FF, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic send_rand_frame();
        int nb, bad, bkb, n;
        logic [63:0] lk;
        nb = int'($urandom_range(10, 8));
        case ($urandom_range(3))
            0: lk = 64'h3FF;
            1: lk = 64'h1FF;
            2: begin n = int'($urandom_range(64, 1)); lk = (64'd1 << n) - 64'd1; end
            default: lk = {$urandom, $urandom};
        endcase
        bad = ($urandom_range(3) == 0) ? int'($urandom_range(64*nb - 1, 1)) : -1;
        bkb = ($urandom_range(4) == 0) ? int'($urandom_range(nb - 1)) : -1;
        send_frame(0, nb, lk, bad, 1'($urandom), bkb, 1'b0);
    endtask

    // Monitor: any change of the outputs is one DUT response, matched against the queue head.
    initial begin
        snap_t prev, cur, e;
        @(negedge aclk);
        prev = dut_snap();
        forever begin
            @(negedge aclk);
            cur = dut_snap();
            if (cur != prev) begin
                n_chk++;
                if (expq.size() == 0) begin
                    $display("FAIL evt: unexpected output change st=%0d pkt=%0d bytes=%0d", cur.st, cur.pkt, cur.bytes);
                end else begin
                    e = expq.pop_front();
                    if (cur === e) n_pass++;
                    else $display("FAIL evt: got st=%0d pkt=%0d bytes=%0d fcs=%0d len=%0d data=%0d busy=%0b done=%0b required st=%0d pkt=%0d bytes=%0d fcs=%0d len=%0d data=%0d busy=%0b done=%0b",
                                  cur.st, cur.pkt, cur.bytes, cur.fcs, cur.lerr, cur.derr, cur.busy, cur.done,
                                  e.st, e.pkt, e.bytes, e.fcs, e.lerr, e.derr, e.busy, e.done);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_push = model_snap();
        #1 aresetn = 1'b0;
        #2;
        chk("rst_state", rx_state, 0);
        chk("rst_pkt", rx_pkt_cnt, 0);
        chk("rst_bytes", rx_byte_cnt, 0);
        chk("rst_errs", rx_fcs_err_cnt + rx_len_err_cnt + rx_data_err_cnt, 0);
        chk("rst_busy", rx_busy_led, 0);
        chk("rst_done", rx_done_led, 0);
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1;

        // Not aligned: stays idle; alignment moves to SYNC.
        idle(1'b0, 1'b0); idle(1'b0, 1'b0);
        chk("idle_unaligned", rx_state, 0);
        idle(1'b1, 1'b0);
        chk("sync_state", rx_state, 1);
        chk("sync_busy", rx_busy_led, 1);

        // Mid-frame start is discarded, then a full run to DONE.
        gap_pct = 20;
        send_frame(5, 9, 64'h3FF, -1, 1'b0, -1, 1'b0);
        chk("rx_after_sync", rx_state, 2);
        chk("sync_uncounted", rx_pkt_cnt, 0);
        repeat (PKT_NUM) send_good();
        chk("run_pkt", rx_pkt_cnt, 1000);
        chk("run_bytes", rx_byte_cnt, 522000);
        chk("run_fcs", rx_fcs_err_cnt, 0);
        chk("run_len", rx_len_err_cnt, 0);
        chk("run_data", rx_data_err_cnt, 0);
        chk("run_done", rx_state, 3);
        chk("run_done_led", rx_done_led, 1);
        send_good(); send_good();
        chk("done_frozen", rx_pkt_cnt, 1000);

        // Error classification.
        idle(1'b1, 1'b1);
        chk("restart_pkt", rx_pkt_cnt, 0);
        chk("restart_state", rx_state, 0);
        idle(1'b1, 1'b0);
        send_frame(8, 9, 64'h3FF, -1, 1'b0, -1, 1'b0);
        send_frame(0, 9, 64'h3FF, -1, 1'b1, -1, 1'b0);
        send_frame(0, 9, 64'h3FF, 100, 1'b0, -1, 1'b0);
        send_frame(0, 9, 64'h1FF, -1, 1'b0, -1, 1'b0);
        send_frame(0, 10, 64'h3FF, -1, 1'b0, -1, 1'b0);
        send_frame(0, 9, 64'h5, -1, 1'b0, -1, 1'b0);
        chk("err_pkt", rx_pkt_cnt, 5);
        chk("err_fcs", rx_fcs_err_cnt, 1);
        chk("err_data", rx_data_err_cnt, 1);
        chk("err_len", rx_len_err_cnt, 3);
        chk("err_bytes", rx_byte_cnt, 2665);
        send_frame(0, 9, 64'h3FF, -1, 1'b0, 3, 1'b0);
        chk("holed_keep_len", rx_len_err_cnt, 4);
        chk("holed_keep_bytes", rx_byte_cnt, 3187);
        repeat (40) send_rand_frame();

        // Alignment loss mid-frame at count 37.
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        send_frame(8, 9, 64'h3FF, -1, 1'b0, -1, 1'b0);
        repeat (37) send_good();
        chk("pre_drop_pkt", rx_pkt_cnt, 37);
        cycle(1'b1, pat_beat(0), {64{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, pat_beat(1), {64{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_state", rx_state, 0);
        chk("drop_pkt", rx_pkt_cnt, 37);
        chk("drop_bytes", rx_byte_cnt, 37 * 522);
        idle(1'b0, 1'b0); idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        chk("realign_sync", rx_state, 1);
        send_good();
        chk("realign_rx", rx_state, 2);
        chk("realign_uncounted", rx_pkt_cnt, 37);
        repeat (3) send_good();
        chk("realign_pkt", rx_pkt_cnt, 40);

        // Restart on the same cycle as tlast wins.
        send_frame(0, 9, 64'h3FF, -1, 1'b0, -1, 1'b1);
        chk("rs_last_pkt", rx_pkt_cnt, 0);
        chk("rs_last_bytes", rx_byte_cnt, 0);
        chk("rs_last_state", rx_state, 0);

        // Continuous mode never reaches DONE.
        rx_continuous = 1'b1;
        idle(1'b1, 1'b0);
        send_frame(8, 9, 64'h3FF, -1, 1'b0, -1, 1'b0);
        repeat (1200) send_good();
        chk("cont_pkt", rx_pkt_cnt, 1200);
        chk("cont_bytes", rx_byte_cnt, 1200 * 522);
        chk("cont_state", rx_state, 2);

        // Asynchronous reset between edges while mid-frame in RX.
        cycle(1'b1, pat_beat(0), {64{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0);
        rx_axis_tvalid = 1'b0;
        #2;
        model_zero(); m_st = 0; f_keep.delete(); f_dbad = 0;
        push_exp();
        aresetn = 1'b0;
        #1;
        chk("arst_state", rx_state, 0);
        chk("arst_pkt", rx_pkt_cnt, 0);
        chk("arst_bytes", rx_byte_cnt, 0);
        chk("arst_busy", rx_busy_led, 0);
        chk("arst_done", rx_done_led, 0);
        @(posedge aclk); #1;
        chk("arst_held", rx_state, 0);
        @(posedge aclk); #2;
        aresetn = 1'b1;
        rx_continuous = 1'b0;
        idle(1'b1, 1'b0);
        chk("post_arst_sync", rx_state, 1);

        repeat (3) @(posedge aclk);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
